pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM generator and successor to the fixed 16-output, 8-bit PWM peripheral. It sits behind the SPI register peripheral, which drives its config write port and the per-channel enable vectors. One shared prescaled counter feeds NUM_CH comparators, and each channel drives one pin. New features: edge- or centre-aligned mode, programmable period and prescaler, and double-buffered duty/period updates that take effect only at period boundaries, so no glitched cycles.

---
 rtl/pwm_multi_pkg.sv | 10 +
 rtl/pwm_channel.sv | 38 +++
 rtl/pwm_multi_channel.sv | 92 +++++++++
 tb/tb_pwm_multi_channel.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: register map, CTRL bit positions and counter mode for pwm_multi_channel
package pwm_multi_pkg;
  localparam int ADDR_CTRL = 'h00;
  localparam int ADDR_TOP = 'h01;
  localparam int ADDR_PRESC = 'h02;
  localparam int ADDR_DUTY_BASE = 'h10;
  localparam int CTRL_MODE = 0;
  localparam int CTRL_RUN = 1;
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTRE = 1'b1} mode_e;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: double-buffered duty, compare against shared counter, enable mux and output flop
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             pwm_out
);
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic pwm_q, pwm_d, raw;
  always_comb begin
    duty_sh_d = we ? wdata : duty_sh_q;
    duty_act_d = load ? duty_sh_q : duty_act_q;
    raw = run && cnt < duty_act_q;
    pwm_d = en_out && (!en_pwm || raw);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '0;
      duty_act_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_out = pwm_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared prescaled edge/centre counter driving NUM_CH double-buffered PWM channels
module pwm_multi_channel
  import pwm_multi_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);
  mode_e mode_q, mode_d;
  logic run_q, run_d, down_q, down_d, new_q, new_d, ps_q, ps_d;
  logic [CNT_W-1:0] top_sh_q, top_sh_d, top_act_q, top_act_d;
  logic [CNT_W-1:0] presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic [CNT_W-1:0] pre_q, pre_d, cnt_q, cnt_d;
  logic ctrl_wr, restart, tick, wrap, load;
  always_comb begin
    ctrl_wr = cfg_we && cfg_addr == ADDR_W'(ADDR_CTRL);
    mode_d = ctrl_wr ? mode_e'(cfg_wdata[CTRL_MODE]) : mode_q;
    run_d = ctrl_wr ? cfg_wdata[CTRL_RUN] : run_q;
    restart = ctrl_wr && (mode_d != mode_q || (run_d && !run_q));
    tick = run_q && pre_q >= presc_act_q;
    wrap = top_act_q == '0 || (mode_q == MODE_EDGE ? cnt_q >= top_act_q : down_q && cnt_q == CNT_W'(1));
    load = !run_q || (tick && wrap);
    top_sh_d = cfg_we && cfg_addr == ADDR_W'(ADDR_TOP) ? cfg_wdata : top_sh_q;
    presc_sh_d = cfg_we && cfg_addr == ADDR_W'(ADDR_PRESC) ? cfg_wdata : presc_sh_q;
    top_act_d = load ? top_sh_q : top_act_q;
    presc_act_d = load ? presc_sh_q : presc_act_q;
    pre_d = restart || !run_q || tick ? '0 : pre_q + CNT_W'(1);
    cnt_d = cnt_q;
    down_d = down_q;
    if (restart || !run_q || (tick && wrap)) begin
      cnt_d = '0;
      down_d = 1'b0;
    end else if (tick) begin
      cnt_d = mode_q == MODE_CENTRE && down_q ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
      down_d = mode_q == MODE_CENTRE && (down_q || cnt_d >= top_act_q);
    end
    new_d = restart ? run_d : tick && wrap;
    ps_d = new_q && run_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_EDGE;
      run_q <= 1'b0;
      top_sh_q <= '1;
      top_act_q <= '1;
      presc_sh_q <= '0;
      presc_act_q <= '0;
      pre_q <= '0;
      cnt_q <= '0;
      down_q <= 1'b0;
      new_q <= 1'b0;
      ps_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      run_q <= run_d;
      top_sh_q <= top_sh_d;
      top_act_q <= top_act_d;
      presc_sh_q <= presc_sh_d;
      presc_act_q <= presc_act_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      down_q <= down_d;
      new_q <= new_d;
      ps_q <= ps_d;
    end
  end
  assign period_start = ps_q;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .we(cfg_we && cfg_addr == ADDR_W'(ADDR_DUTY_BASE + k)),
      .wdata(cfg_wdata),
      .load(load),
      .run(run_q),
      .cnt(cnt_q),
      .en_out(en_out[k]),
      .en_pwm(en_pwm[k]),
      .pwm_out(pwm_out[k])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed and random stimulus checked against a period-phase reference model
module tb_pwm_multi_channel;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 8;
  localparam int ADDR_W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [CNT_W-1:0] cfg_wdata = '0;
  logic [NUM_CH-1:0] en_out = '0;
  logic [NUM_CH-1:0] en_pwm = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic period_start;
  int errors = 0;
  int checks = 0;
  int hi[NUM_CH];
  int ps_cnt;
  bit m_run, m_mode, m_new;
  int m_top_sh, m_top, m_presc_sh, m_presc, m_sub, m_p;
  int m_duty_sh[NUM_CH];
  int m_duty[NUM_CH];
  always #5 clk = ~clk;
  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .en_out(en_out),
    .en_pwm(en_pwm),
    .pwm_out(pwm_out),
    .period_start(period_start)
  );
  function automatic int m_len();
    return m_mode ? (m_top == 0 ? 1 : 2 * m_top) : m_top + 1;
  endfunction
  function automatic int m_cnt();
    return (m_mode && m_p > m_top) ? 2 * m_top - m_p : m_p;
  endfunction
  function automatic bit m_bnd_next();
    return m_run && m_sub == m_presc && m_p == m_len() - 1;
  endfunction
  task automatic m_reset();
    m_run = 0; m_mode = 0; m_new = 0;
    m_top_sh = 255; m_top = 255; m_presc_sh = 0; m_presc = 0; m_sub = 0; m_p = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_duty_sh[k] = 0;
      m_duty[k] = 0;
    end
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    logic [NUM_CH-1:0] e_pwm;
    logic e_ps;
    bit bnd, tick, restart, nm, nr;
    int a;
    a = int'(cfg_addr);
    if (rst) begin
      e_pwm = '0;
      e_ps = 1'b0;
      m_reset();
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        e_pwm[k] = en_out[k] && (!en_pwm[k] || (m_run && m_cnt() < m_duty[k]));
      e_ps = m_new && m_run;
      bnd = m_bnd_next();
      tick = m_run && m_sub == m_presc;
      nm = m_mode;
      nr = m_run;
      if (cfg_we && a == 0) begin
        nm = cfg_wdata[0];
        nr = cfg_wdata[1];
      end
      restart = cfg_we && a == 0 && (nm != m_mode || (nr && !m_run));
      if (!m_run || bnd) begin
        m_top = m_top_sh;
        m_presc = m_presc_sh;
        for (int k = 0; k < NUM_CH; k++) m_duty[k] = m_duty_sh[k];
      end
      if (cfg_we && a == 1) m_top_sh = int'(cfg_wdata);
      if (cfg_we && a == 2) m_presc_sh = int'(cfg_wdata);
      if (cfg_we && a >= 16 && a < 16 + NUM_CH) m_duty_sh[a - 16] = int'(cfg_wdata);
      if (restart || !m_run) begin
        m_sub = 0;
        m_p = 0;
      end else if (tick) begin
        m_sub = 0;
        m_p = bnd ? 0 : m_p + 1;
      end else m_sub++;
      m_new = restart ? nr : bnd;
      m_mode = nm;
      m_run = nr;
    end
    @(posedge clk);
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
    chk("period_start", 32'(period_start), 32'(e_ps));
    for (int k = 0; k < NUM_CH; k++) hi[k] += int'(pwm_out[k]);
    ps_cnt += int'(period_start);
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic wr(int a, int d);
    cfg_we = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_wdata = CNT_W'(d);
    step();
    cfg_we = 1'b0;
  endtask
  task automatic window(int n);
    for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
    ps_cnt = 0;
    idle(n);
  endtask
  task automatic wait_bnd();
    int n = 0;
    while (!m_bnd_next() && n < 100) begin
      step();
      n++;
    end
    chk("bnd_found", 32'(n < 100), 32'd1);
  endtask
  initial begin
    m_reset();
    idle(2);
    rst = 1'b0;
    en_out = '1;
    en_pwm = '1;
    wr(1, 9); wr(2, 0); wr('h10, 3); wr('h11, 3); wr(0, 2);
    idle(12);
    window(20);
    chk("edge_hi", hi[0], 6);
    chk("edge_ps", ps_cnt, 2);
    idle(4);
    wr('h10, 7);
    wait_bnd();
    wr('h10, 5);
    window(10);
    chk("bnd_wr_keep", hi[0], 7);
    chk("bnd_wr_ps", ps_cnt, 1);
    window(10);
    chk("bnd_wr_next", hi[0], 5);
    wr(0, 0); wr(1, 4); wr('h11, 2); wr(0, 3);
    idle(10);
    window(16);
    chk("centre_hi", hi[1], 6);
    chk("centre_ps", ps_cnt, 2);
    chk("centre_gt_top", hi[0], 16);
    wr(0, 0); wr(1, 9); wr('h10, 0); wr('h11, 10); wr('h12, 4); wr('h13, 5); wr(0, 2);
    idle(5);
    window(20);
    chk("duty0_low", hi[0], 0);
    chk("duty_top1_high", hi[1], 20);
    chk("duty4_hi", hi[2], 8);
    en_pwm = 4'b1011;
    en_out = 4'b0111;
    window(10);
    chk("en_pwm0_high", hi[2], 10);
    chk("en_out0_low", hi[3], 0);
    en_out = '1;
    en_pwm = '1;
    wr(0, 0); wr(2, 2); wr(1, 3); wr('h10, 2); wr('h14, 9); wr('h05, 1); wr(0, 2);
    idle(14);
    window(24);
    chk("presc_hi", hi[0], 12);
    chk("presc_ps", ps_cnt, 2);
    chk("presc_gt_top", hi[1], 24);
    wr(0, 0); wr(1, 9); wr(2, 0); wr('h10, 3); wr(0, 2);
    idle(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr('h10, 128); wr(0, 2);
    idle(3);
    window(256);
    chk("rst_top_hi", hi[0], 128);
    chk("rst_top_ps", ps_cnt, 1);
    wr(0, 0); wr(0, 1); wr(0, 3);
    idle(20);
    wr(0, 2);
    idle(20);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 19) == 0) begin
        en_out = NUM_CH'($urandom);
        en_pwm = NUM_CH'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 15))
          0: wr(0, int'($urandom_range(0, 3)));
          1, 2: wr(1, int'($urandom_range(0, 12)));
          3: wr(2, int'($urandom_range(0, 2)));
          4: wr('h14, int'($urandom_range(0, 255)));
          5: wr(int'($urandom_range(0, 255)), int'($urandom_range(0, 20)));
          default: wr('h10 + int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 14)));
        endcase
      end else step();
      if (i % 500 == 0) begin
        rst = 1'b0;
        wr(0, 2 + int'($urandom_range(0, 1)));
      end
    end
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
